// File: rtl/nasti_burst_to_lite_writer.sv
// Replays a NASTI INCR write burst as single-beat NASTI-Lite writes and folds the Lite responses into one B.
// Optional NASTI_B2L_SKIP_ZERO_STRB_EN: beats with an all-zero strobe are dropped instead of written.
module nasti_burst_to_lite_writer #(
    parameter int ID_WIDTH   = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int USER_WIDTH = 1
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [ID_WIDTH-1:0]     nasti_aw_id,
    input  logic [ADDR_WIDTH-1:0]   nasti_aw_addr,
    input  logic [7:0]              nasti_aw_len,
    input  logic [2:0]              nasti_aw_size,
    input  logic [1:0]              nasti_aw_burst,
    input  logic [2:0]              nasti_aw_prot,
    input  logic [USER_WIDTH-1:0]   nasti_aw_user,
    input  logic                    nasti_aw_valid,
    output logic                    nasti_aw_ready,
    input  logic [DATA_WIDTH-1:0]   nasti_w_data,
    input  logic [DATA_WIDTH/8-1:0] nasti_w_strb,
    input  logic                    nasti_w_last,
    input  logic                    nasti_w_valid,
    output logic                    nasti_w_ready,
    output logic [ID_WIDTH-1:0]     nasti_b_id,
    output logic [1:0]              nasti_b_resp,
    output logic [USER_WIDTH-1:0]   nasti_b_user,
    output logic                    nasti_b_valid,
    input  logic                    nasti_b_ready,
    output logic [ADDR_WIDTH-1:0]   lite_aw_addr,
    output logic [2:0]              lite_aw_prot,
    output logic                    lite_aw_valid,
    input  logic                    lite_aw_ready,
    output logic [DATA_WIDTH-1:0]   lite_w_data,
    output logic [DATA_WIDTH/8-1:0] lite_w_strb,
    output logic                    lite_w_valid,
    input  logic                    lite_w_ready,
    input  logic [1:0]              lite_b_resp,
    input  logic                    lite_b_valid,
    output logic                    lite_b_ready
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BEAT,
        S_LB,
        S_B
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [ID_WIDTH-1:0]   id_q;
    logic [7:0]            len_q;
    logic [2:0]            size_q;
    logic [2:0]            prot_q;
    logic [USER_WIDTH-1:0] user_q;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [7:0]            cnt;
    logic [1:0]            acc;
    logic                  aw_done;
    logic                  w_done;
    logic                  armed;

    logic                  aw_hs;
    logic                  w_hs;
    logic                  last_beat;
    logic                  advance;
    logic                  skip_beat;
    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] next_addr;

    assign last_beat = (cnt == len_q);
    assign step      = ADDR_WIDTH'(1) << size_q;
    assign next_addr = (cur_addr & ~(step - ADDR_WIDTH'(1))) + step;

    assign aw_hs = lite_aw_valid && lite_aw_ready;
    assign w_hs  = lite_w_valid && lite_w_ready;

    assign lite_aw_addr = cur_addr;
    assign lite_aw_prot = prot_q;
    assign lite_w_data  = nasti_w_data;
    assign lite_w_strb  = nasti_w_strb;
    assign nasti_b_id   = id_q;
    assign nasti_b_resp = acc;
    assign nasti_b_user = user_q;

    // State register; reset abandons any burst in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs for the replay sequence.
    always_comb begin
        state_nxt      = state;
        nasti_aw_ready = 1'b0;
        nasti_w_ready  = 1'b0;
        nasti_b_valid  = 1'b0;
        lite_aw_valid  = 1'b0;
        lite_w_valid   = 1'b0;
        lite_b_ready   = 1'b0;
        skip_beat      = 1'b0;
        advance        = 1'b0;
        unique case (state)
            S_IDLE: begin
                nasti_aw_ready = armed;
                if (nasti_aw_valid && armed) begin
                    state_nxt = S_BEAT;
                end
            end
            S_BEAT: begin
`ifdef NASTI_B2L_SKIP_ZERO_STRB_EN
                skip_beat = nasti_w_valid && !aw_done && !w_done
                            && (nasti_w_strb == '0);
                lite_aw_valid = !aw_done
                                && (w_done || (nasti_w_valid && nasti_w_strb != '0));
                lite_w_valid  = nasti_w_valid && !w_done && !skip_beat;
                nasti_w_ready = skip_beat || (lite_w_ready && !w_done);
`else
                lite_aw_valid = !aw_done;
                lite_w_valid  = nasti_w_valid && !w_done;
                nasti_w_ready = lite_w_ready && !w_done;
`endif
                if (skip_beat) begin
                    advance   = 1'b1;
                    state_nxt = last_beat ? S_B : S_BEAT;
                end else if ((aw_done || (lite_aw_valid && lite_aw_ready))
                             && (w_done || (lite_w_valid && lite_w_ready))) begin
                    state_nxt = S_LB;
                end
            end
            S_LB: begin
                lite_b_ready = 1'b1;
                if (lite_b_valid) begin
                    advance   = 1'b1;
                    state_nxt = last_beat ? S_B : S_BEAT;
                end
            end
            S_B: begin
                nasti_b_valid = 1'b1;
                if (nasti_b_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Burst context, beat progress and first-error response accumulation.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            id_q     <= '0;
            len_q    <= '0;
            size_q   <= '0;
            prot_q   <= '0;
            user_q   <= '0;
            cur_addr <= '0;
            cnt      <= '0;
            acc      <= 2'b00;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            armed    <= 1'b0;
        end else begin
            armed <= 1'b1;
            if (state == S_IDLE && nasti_aw_valid && nasti_aw_ready) begin
                id_q     <= nasti_aw_id;
                len_q    <= nasti_aw_len;
                size_q   <= nasti_aw_size;
                prot_q   <= nasti_aw_prot;
                user_q   <= nasti_aw_user;
                cur_addr <= nasti_aw_addr;
                cnt      <= '0;
                acc      <= 2'b00;
                aw_done  <= 1'b0;
                w_done   <= 1'b0;
            end
            if (state == S_BEAT) begin
                if (state_nxt == S_LB) begin
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                end else begin
                    if (aw_hs) aw_done <= 1'b1;
                    if (w_hs)  w_done  <= 1'b1;
                end
            end
            if (state == S_LB && lite_b_valid && acc == 2'b00 && lite_b_resp[1]) begin
                acc <= lite_b_resp;
            end
            if (advance && !last_beat) begin
                cnt      <= cnt + 8'd1;
                cur_addr <= next_addr;
            end
        end
    end

`ifndef SYNTHESIS
    // Flag bursts this bridge cannot replay and masters that mis-mark the last beat.
    always_ff @(posedge clk) begin
        if (rstn && state == S_IDLE && nasti_aw_valid && nasti_aw_ready) begin
            assert (nasti_aw_burst == 2'b01
                    && (32'd1 << nasti_aw_size) <= 32'(STRB_WIDTH))
            else $fatal(1, "unsupported burst type or size");
        end
        if (rstn && state == S_BEAT && nasti_w_valid && nasti_w_ready) begin
            assert (nasti_w_last == last_beat)
            else $error("w_last does not match beat count");
        end
    end
`endif

endmodule

// File: tb/tb_nasti_burst_to_lite_writer.sv
// Randomised bench for nasti_burst_to_lite_writer: a burst master, a delaying Lite slave
// and a reference model of expected Lite writes and the collapsed B response.
`timescale 1ns/1ps
module tb_nasti_burst_to_lite_writer;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [1:0]  nasti_aw_id;
    logic [31:0] nasti_aw_addr;
    logic [7:0]  nasti_aw_len;
    logic [2:0]  nasti_aw_size;
    logic [1:0]  nasti_aw_burst;
    logic [2:0]  nasti_aw_prot;
    logic [0:0]  nasti_aw_user;
    logic        nasti_aw_valid;
    logic        nasti_aw_ready;
    logic [31:0] nasti_w_data;
    logic [3:0]  nasti_w_strb;
    logic        nasti_w_last;
    logic        nasti_w_valid;
    logic        nasti_w_ready;
    logic [1:0]  nasti_b_id;
    logic [1:0]  nasti_b_resp;
    logic [0:0]  nasti_b_user;
    logic        nasti_b_valid;
    logic        nasti_b_ready;
    logic [31:0] lite_aw_addr;
    logic [2:0]  lite_aw_prot;
    logic        lite_aw_valid;
    logic        lite_aw_ready;
    logic [31:0] lite_w_data;
    logic [3:0]  lite_w_strb;
    logic        lite_w_valid;
    logic        lite_w_ready;
    logic [1:0]  lite_b_resp;
    logic        lite_b_valid;
    logic        lite_b_ready;

    always #5 clk = ~clk;

    nasti_burst_to_lite_writer dut (
        .clk(clk), .rstn(rstn),
        .nasti_aw_id(nasti_aw_id), .nasti_aw_addr(nasti_aw_addr),
        .nasti_aw_len(nasti_aw_len), .nasti_aw_size(nasti_aw_size),
        .nasti_aw_burst(nasti_aw_burst), .nasti_aw_prot(nasti_aw_prot),
        .nasti_aw_user(nasti_aw_user), .nasti_aw_valid(nasti_aw_valid),
        .nasti_aw_ready(nasti_aw_ready),
        .nasti_w_data(nasti_w_data), .nasti_w_strb(nasti_w_strb),
        .nasti_w_last(nasti_w_last), .nasti_w_valid(nasti_w_valid),
        .nasti_w_ready(nasti_w_ready),
        .nasti_b_id(nasti_b_id), .nasti_b_resp(nasti_b_resp),
        .nasti_b_user(nasti_b_user), .nasti_b_valid(nasti_b_valid),
        .nasti_b_ready(nasti_b_ready),
        .lite_aw_addr(lite_aw_addr), .lite_aw_prot(lite_aw_prot),
        .lite_aw_valid(lite_aw_valid), .lite_aw_ready(lite_aw_ready),
        .lite_w_data(lite_w_data), .lite_w_strb(lite_w_strb),
        .lite_w_valid(lite_w_valid), .lite_w_ready(lite_w_ready),
        .lite_b_resp(lite_b_resp), .lite_b_valid(lite_b_valid),
        .lite_b_ready(lite_b_ready)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] bd_data[$];
    logic [3:0]  bd_strb[$];
    logic [1:0]  br_resp[$];
    logic [67:0] exp_wr[$];
    logic [67:0] got_wr[$];
    logic [31:0] got_aw[$];
    logic [35:0] got_w[$];
    logic [4:0]  exp_b;
    logic [4:0]  got_b;
    int          nb;
    bit          timed_out;
    bit          early_b;

    task automatic idle_inputs();
        nasti_aw_valid = 1'b0;
        nasti_aw_id    = '0;
        nasti_aw_addr  = '0;
        nasti_aw_len   = '0;
        nasti_aw_size  = '0;
        nasti_aw_burst = 2'b01;
        nasti_aw_prot  = '0;
        nasti_aw_user  = '0;
        nasti_w_valid  = 1'b0;
        nasti_w_data   = '0;
        nasti_w_strb   = '0;
        nasti_w_last   = 1'b0;
        nasti_b_ready  = 1'b0;
        lite_aw_ready  = 1'b0;
        lite_w_ready   = 1'b0;
        lite_b_valid   = 1'b0;
        lite_b_resp    = 2'b00;
    endtask

    task automatic fill(input int n);
        bd_data.delete();
        bd_strb.delete();
        br_resp.delete();
        for (int i = 0; i < n; i++) begin
            bd_data.push_back($urandom);
            bd_strb.push_back(4'($urandom));
            br_resp.push_back(2'b00);
        end
    endtask

    // Drives one burst through master and slave models; fills exp_* from the
    // specification's address/response rules and got_* from observed traffic.
    task automatic run_burst(input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] id,
                             input logic user, input int aw_lo, input int aw_hi,
                             input int w_hi, input int b_hi, input int abort_at);
        logic [31:0] base;
        logic [31:0] a;
        logic [1:0]  acc;
        int          k, wi, naw, nw, nbi, pend, aw_w, w_w, b_w, limit;
        bit          aw_sent, skip;
        exp_wr.delete();
        got_wr.delete();
        got_aw.delete();
        got_w.delete();
        base = addr & ~((32'd1 << size) - 32'd1);
        acc = 2'b00;
        k = 0;
        for (int i = 0; i <= int'(len); i++) begin
            a = (i == 0) ? addr : base + 32'(i) * (32'd1 << size);
            skip = 1'b0;
`ifdef NASTI_B2L_SKIP_ZERO_STRB_EN
            skip = (bd_strb[i] == 4'h0);
`endif
            if (!skip) begin
                exp_wr.push_back({a, bd_data[i], bd_strb[i]});
                if (acc == 2'b00 && k < br_resp.size() && br_resp[k][1]) acc = br_resp[k];
                k++;
            end
        end
        exp_b = {id, acc, user};
        got_b = '0;
        nb = 0;
        early_b = 1'b0;
        timed_out = 1'b1;
        aw_sent = 1'b0;
        wi = 0;
        naw = 0;
        nw = 0;
        nbi = 0;
        aw_w = $urandom_range(aw_hi, aw_lo);
        w_w = $urandom_range(w_hi, 0);
        b_w = $urandom_range(b_hi, 0);
        limit = 24 * (int'(len) + 1) + 100;
        for (int cyc = 0; cyc < limit; cyc++) begin
            @(negedge clk);
            nasti_aw_valid = !aw_sent;
            nasti_aw_id    = id;
            nasti_aw_addr  = addr;
            nasti_aw_len   = len;
            nasti_aw_size  = size;
            nasti_aw_burst = 2'b01;
            nasti_aw_prot  = 3'b010;
            nasti_aw_user  = user;
            nasti_w_valid  = (wi <= int'(len));
            nasti_w_data   = '0;
            nasti_w_strb   = '0;
            if (wi <= int'(len)) begin
                nasti_w_data = bd_data[wi];
                nasti_w_strb = bd_strb[wi];
            end
            nasti_w_last  = (wi == int'(len));
            lite_aw_ready = (aw_w == 0);
            lite_w_ready  = (w_w == 0);
            pend = ((naw < nw) ? naw : nw) - nbi;
            lite_b_valid  = (pend > 0) && (b_w == 0);
            lite_b_resp   = 2'b00;
            if (nbi < br_resp.size()) lite_b_resp = br_resp[nbi];
            nasti_b_ready = ($urandom_range(3, 0) != 0);
            #1;
            if (nasti_b_valid && nbi < exp_wr.size()) early_b = 1'b1;
            if (nasti_aw_valid && nasti_aw_ready) aw_sent = 1'b1;
            if (nasti_w_valid && nasti_w_ready) wi++;
            if (lite_aw_valid && lite_aw_ready) begin
                got_aw.push_back(lite_aw_addr);
                naw++;
                aw_w = $urandom_range(aw_hi, aw_lo);
            end else if (lite_aw_valid && aw_w > 0) begin
                aw_w--;
            end
            if (lite_w_valid && lite_w_ready) begin
                got_w.push_back({lite_w_data, lite_w_strb});
                nw++;
                w_w = $urandom_range(w_hi, 0);
            end else if (lite_w_valid && w_w > 0) begin
                w_w--;
            end
            if (lite_b_valid && lite_b_ready) begin
                nbi++;
                b_w = $urandom_range(b_hi, 0);
            end else if (pend > 0 && b_w > 0) begin
                b_w--;
            end
            if (nasti_b_valid && nasti_b_ready) begin
                got_b = {nasti_b_id, nasti_b_resp, nasti_b_user};
                nb++;
            end
            if (abort_at >= 0 && nbi == abort_at) begin
                timed_out = 1'b0;
                return;
            end
            if (nb > 0) begin
                timed_out = 1'b0;
                break;
            end
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            idle_inputs();
            #1;
            if (nasti_b_valid) nb++;
        end
        for (int i = 0; i < got_aw.size() && i < got_w.size(); i++) begin
            got_wr.push_back({got_aw[i], got_w[i]});
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        nasti_aw_valid = 1'b1;
        nasti_w_valid  = 1'b1;
        lite_b_valid   = 1'b1;
        lite_aw_ready  = 1'b1;
        lite_w_ready   = 1'b1;
        #1;
        checks++;
        if ({nasti_aw_ready, nasti_w_ready, nasti_b_valid, lite_aw_valid,
             lite_w_valid, lite_b_ready} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 000000",
                     {nasti_aw_ready, nasti_w_ready, nasti_b_valid,
                      lite_aw_valid, lite_w_valid, lite_b_ready});
        end
        checks++;
        if (nasti_b_resp !== 2'b00) begin
            errors++;
            $display("FAIL reset_acc: got %b want 00", nasti_b_resp);
        end
        @(negedge clk);
        idle_inputs();
        rstn = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (nasti_aw_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_awready: got %b want 1", nasti_aw_ready);
        end
    endtask

    task automatic test_single();
        fill(1);
        bd_data[0] = 32'hDEADBEEF;
        bd_strb[0] = 4'hF;
        run_burst(32'h100, 8'd0, 3'd2, 2'd1, 1'b0, 0, 0, 0, 0, -1);
        checks++;
        if (timed_out || nb !== 1) begin
            errors++;
            $display("FAIL single_bcount: got %0d timeout=%0d want 1", nb, timed_out);
        end
        checks++;
        if (got_b !== 5'b01_00_0) begin
            errors++;
            $display("FAIL single_b: got %b want 01000", got_b);
        end
        checks++;
        if (got_wr.size() !== 1 || got_wr[0] !== {32'h100, 32'hDEADBEEF, 4'hF}) begin
            errors++;
            $display("FAIL single_write: got %0d writes first %h", got_wr.size(),
                     got_wr.size() > 0 ? got_wr[0] : 68'h0);
        end
    endtask

    task automatic test_backpressure();
        fill(4);
        for (int i = 0; i < 4; i++) bd_strb[i] = 4'hF;
        run_burst(32'h200, 8'd3, 3'd2, 2'd2, 1'b1, 2, 2, 3, 2, -1);
        checks++;
        if (timed_out || nb !== 1) begin
            errors++;
            $display("FAIL bp_bcount: got %0d timeout=%0d want 1", nb, timed_out);
        end
        checks++;
        if (got_b !== exp_b) begin
            errors++;
            $display("FAIL bp_b: got %b want %b", got_b, exp_b);
        end
        checks++;
        if (got_wr.size() !== exp_wr.size()) begin
            errors++;
            $display("FAIL bp_nwrites: got %0d want %0d", got_wr.size(), exp_wr.size());
        end
        for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++) begin
            checks++;
            if (got_wr[i] !== exp_wr[i]) begin
                errors++;
                $display("FAIL bp_write%0d: got %h want %h", i, got_wr[i], exp_wr[i]);
            end
        end
    endtask

    task automatic test_errors();
        fill(3);
        br_resp[0] = 2'b00;
        br_resp[1] = 2'b10;
        br_resp[2] = 2'b11;
        run_burst(32'h400, 8'd2, 3'd2, 2'd3, 1'b0, 0, 1, 1, 3, -1);
        checks++;
        if (timed_out || nb !== 1) begin
            errors++;
            $display("FAIL err_bcount: got %0d timeout=%0d want 1", nb, timed_out);
        end
        checks++;
        if (got_b !== {2'd3, 2'b10, 1'b0}) begin
            errors++;
            $display("FAIL err_b: got %b want 11100", got_b);
        end
        checks++;
        if (early_b) begin
            errors++;
            $display("FAIL err_early_b: got early=1 want 0");
        end
    endtask

    task automatic test_unaligned();
        fill(2);
        run_burst(32'h103, 8'd1, 3'd2, 2'd0, 1'b0, 0, 1, 1, 1, -1);
        checks++;
        if (got_aw.size() !== 2 || got_aw[0] !== 32'h103 || got_aw[1] !== 32'h104) begin
            errors++;
            $display("FAIL unaligned_addr: got n=%0d %h %h want 103 104", got_aw.size(),
                     got_aw.size() > 0 ? got_aw[0] : 32'h0,
                     got_aw.size() > 1 ? got_aw[1] : 32'h0);
        end
        fill(4);
        run_burst(32'h10, 8'd3, 3'd0, 2'd1, 1'b1, 0, 1, 1, 1, -1);
        checks++;
        if (got_wr.size() !== exp_wr.size()) begin
            errors++;
            $display("FAIL size0_nwrites: got %0d want %0d", got_wr.size(), exp_wr.size());
        end
        for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++) begin
            checks++;
            if (got_wr[i] !== exp_wr[i]) begin
                errors++;
                $display("FAIL size0_write%0d: got %h want %h", i, got_wr[i], exp_wr[i]);
            end
        end
        checks++;
        if (nb !== 1 || got_b !== exp_b) begin
            errors++;
            $display("FAIL size0_b: got n=%0d %b want 1 %b", nb, got_b, exp_b);
        end
    endtask

    task automatic test_reset_mid();
        bit saw_b;
        fill(4);
        run_burst(32'h500, 8'd3, 3'd2, 2'd2, 1'b0, 0, 0, 0, 0, 2);
        rstn = 1'b0;
        idle_inputs();
        #1;
        checks++;
        if (timed_out) begin
            errors++;
            $display("FAIL midrst_reach: got timeout=1 want 0");
        end
        checks++;
        if ({nasti_b_valid, lite_aw_valid, lite_w_valid, nasti_aw_ready} !== 4'b0) begin
            errors++;
            $display("FAIL midrst_valids: got %b want 0000",
                     {nasti_b_valid, lite_aw_valid, lite_w_valid, nasti_aw_ready});
        end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        saw_b = 1'b0;
        nasti_b_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            if (nasti_b_valid) saw_b = 1'b1;
        end
        checks++;
        if (saw_b) begin
            errors++;
            $display("FAIL midrst_no_b: got b_valid=1 want 0");
        end
        fill(2);
        run_burst(32'h600, 8'd1, 3'd2, 2'd1, 1'b1, 0, 1, 1, 1, -1);
        checks++;
        if (timed_out || nb !== 1 || got_b !== exp_b || got_wr !== exp_wr) begin
            errors++;
            $display("FAIL midrst_next: got n=%0d b=%b nw=%0d want 1 b=%b nw=%0d",
                     nb, got_b, got_wr.size(), exp_b, exp_wr.size());
        end
    endtask

    task automatic test_long();
        fill(256);
        br_resp.delete();
        for (int i = 0; i < 256; i++) br_resp.push_back(i == 200 ? 2'b11 : 2'b01);
        run_burst(32'h1000, 8'd255, 3'd2, 2'd0, 1'b1, 0, 0, 0, 0, -1);
        checks++;
        if (timed_out || nb !== 1 || got_b !== exp_b) begin
            errors++;
            $display("FAIL long_b: got n=%0d b=%b want 1 b=%b", nb, got_b, exp_b);
        end
        checks++;
        if (got_wr !== exp_wr) begin
            errors++;
            $display("FAIL long_writes: got n=%0d want n=%0d", got_wr.size(), exp_wr.size());
        end
    endtask

    task automatic test_random();
        logic [7:0]  len;
        logic [2:0]  size;
        logic [31:0] addr;
        for (int t = 0; t < 8; t++) begin
            len  = 8'($urandom_range(7, 0));
            size = 3'($urandom_range(2, 0));
            addr = $urandom & 32'h0000_FFFF;
            fill(int'(len) + 1);
            foreach (br_resp[i]) br_resp[i] = 2'($urandom);
            run_burst(addr, len, size, 2'($urandom), 1'($urandom), 0, 3, 3, 3, -1);
            checks++;
            if (timed_out || nb !== 1 || got_b !== exp_b || early_b) begin
                errors++;
                $display("FAIL rand%0d_b: got n=%0d b=%b early=%0d want 1 b=%b",
                         t, nb, got_b, early_b, exp_b);
            end
            checks++;
            if (got_wr !== exp_wr) begin
                errors++;
                $display("FAIL rand%0d_writes: got n=%0d want n=%0d", t,
                         got_wr.size(), exp_wr.size());
            end
        end
    endtask

`ifdef NASTI_B2L_SKIP_ZERO_STRB_EN
    task automatic test_skip();
        fill(3);
        bd_strb[0] = 4'hF;
        bd_strb[1] = 4'h0;
        bd_strb[2] = 4'hF;
        run_burst(32'h300, 8'd2, 3'd2, 2'd2, 1'b0, 0, 1, 1, 1, -1);
        checks++;
        if (got_aw.size() !== 2 || got_aw[0] !== 32'h300 || got_aw[1] !== 32'h308) begin
            errors++;
            $display("FAIL skip_addr: got n=%0d want 300 308", got_aw.size());
        end
        checks++;
        if (nb !== 1 || got_b !== {2'd2, 2'b00, 1'b0}) begin
            errors++;
            $display("FAIL skip_b: got n=%0d b=%b want 1 10000", nb, got_b);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_errors();
        test_unaligned();
        test_reset_mid();
        test_long();
        test_random();
`ifdef NASTI_B2L_SKIP_ZERO_STRB_EN
        test_skip();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
